alu_share_ctrl: RTL and testbench

- Arbiter/sequencer sharing the single combinational ALU between two requesters, e.g. the EX stage (port 0) and the branch/address-compare unit (port 1).
- Accepts one operation at a time over valid/ready, registers the operands onto the ALU inputs, captures the ALU result and zero flag, and returns them to the winning requester.
- Sits between the requesters and the ALU's alua/alub/aluop/alu_output/z pins.

---
 rtl/alu_share_ctrl_if.sv | 41 ++++
 rtl/alu_share_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu_share_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_ctrl_if.sv
// rtl/alu_share_ctrl_if.sv - requester-side handshake bundle for alu_share_ctrl
interface alu_share_ctrl_if #(
  parameter int WIDTH = 32
);
  // port 0 request
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;
  // port 1 request
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;
  // responses share one data path; the valid lines select the owner
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_z;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_z, rsp_err
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_z, rsp_err
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - two-port arbiter/sequencer sharing one combinational ALU
module alu_share_ctrl #(
  parameter int WIDTH    = 32,
  parameter int ARB_MODE = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clrn,
  alu_share_ctrl_if.slave  bus,
  output logic [WIDTH-1:0] alua,
  output logic [WIDTH-1:0] alub,
  output logic [2:0]       aluop,
  input  logic [WIDTH-1:0] alu_output,
  input  logic             alu_z,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;          // round-robin favourite when both request
  logic             id_q, id_d;            // port that owns the op in flight
  logic [WIDTH-1:0] alua_q, alua_d;
  logic [WIDTH-1:0] alub_q, alub_d;
  logic [2:0]       aluop_q, aluop_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_z_q, rsp_z_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             grant_any;
  logic             grant_id;
  logic             accept;
  logic             rsp_take;

  // Pick a winner from the current valids; a lone requester always wins
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = (ARB_MODE == 1) ? 1'b0 : ptr_q;
    end else begin
      grant_id = bus.req1_valid;
    end
  end

  assign bus.req0_ready = (state_q == ST_IDLE) & grant_any & ~grant_id;
  assign bus.req1_ready = (state_q == ST_IDLE) & grant_any &  grant_id;
  assign accept         = (state_q == ST_IDLE) & grant_any;

  assign bus.rsp0_valid = (state_q == ST_RESP) & ~id_q;
  assign bus.rsp1_valid = (state_q == ST_RESP) &  id_q;
  // only the owning port's ready completes the response
  assign rsp_take       = (state_q == ST_RESP) & (id_q ? bus.rsp1_ready : bus.rsp0_ready);

  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_z      = rsp_z_q;
  assign bus.rsp_err    = rsp_err_q;
  assign alua           = alua_q;
  assign alub           = alub_q;
  assign aluop          = aluop_q;
  assign busy           = (state_q != ST_IDLE);
  assign op_count       = op_count_q;

  // Next-state and datapath updates for the IDLE -> EXEC -> RESP sequence
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    alua_d       = alua_q;
    alub_d       = alub_q;
    aluop_d      = aluop_q;
    rsp_result_d = rsp_result_q;
    rsp_z_d      = rsp_z_q;
    rsp_err_d    = rsp_err_q;
    op_count_d   = op_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d    = grant_id;
          alua_d  = grant_id ? bus.req1_a  : bus.req0_a;
          alub_d  = grant_id ? bus.req1_b  : bus.req0_b;
          aluop_d = grant_id ? bus.req1_op : bus.req0_op;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // the ALU output is undefined for the illegal code, so never sample it
        if (aluop_q == OP_ILLEGAL) begin
          rsp_result_d = '0;
          rsp_z_d      = 1'b0;
          rsp_err_d    = 1'b1;
        end else begin
          rsp_result_d = alu_output;
          rsp_z_d      = alu_z;
          rsp_err_d    = 1'b0;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_take) begin
          op_count_d = op_count_q + CNT_W'(1);
          if (ARB_MODE == 0) begin
            ptr_d = ~id_q;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      id_q         <= 1'b0;
      alua_q       <= '0;
      alub_q       <= '0;
      aluop_q      <= '0;
      rsp_result_q <= '0;
      rsp_z_q      <= 1'b0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      alua_q       <= alua_d;
      alub_q       <= alub_d;
      aluop_q      <= aluop_d;
      rsp_result_q <= rsp_result_d;
      rsp_z_q      <= rsp_z_d;
      rsp_err_q    <= rsp_err_d;
      op_count_q   <= op_count_d;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - randomized bench for alu_share_ctrl in both arbitration modes
module tb_alu_share_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  // bench-owned stimulus, [dut][port]
  logic         req_valid [2][2];
  logic [W-1:0] req_a     [2][2];
  logic [W-1:0] req_b     [2][2];
  logic [2:0]   req_op    [2][2];
  logic         rsp_ready [2][2];
  // observed outputs
  logic         req_ready [2][2];
  logic         rsp_valid [2][2];
  logic [W-1:0] rsp_result[2];
  logic         rsp_z     [2];
  logic         rsp_err   [2];
  logic [W-1:0] alua      [2];
  logic [W-1:0] alub      [2];
  logic [2:0]   aluop     [2];
  logic [W-1:0] alu_out   [2];
  logic         alu_zf    [2];
  logic         busy      [2];
  logic [15:0]  cnt       [2];
  logic [W-1:0] garbage;

  // reference ALU outside the DUT; code 111 has no defined result
  function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return b >> a[4:0];
      3'd5:    return b << a[4:0];
      3'd6:    return a - b;
      default: return '0;
    endcase
  endfunction

  // dut 0: round-robin with a narrow counter so wrap happens often; dut 1: fixed priority
  for (genvar m = 0; m < 2; m++) begin : g_dut
    localparam int CW = (m == 0) ? 4 : 16;
    logic [CW-1:0] oc;
    alu_share_ctrl_if #(.WIDTH(W)) ifc ();

    assign ifc.req0_valid = req_valid[m][0];
    assign ifc.req0_a     = req_a[m][0];
    assign ifc.req0_b     = req_b[m][0];
    assign ifc.req0_op    = req_op[m][0];
    assign ifc.req1_valid = req_valid[m][1];
    assign ifc.req1_a     = req_a[m][1];
    assign ifc.req1_b     = req_b[m][1];
    assign ifc.req1_op    = req_op[m][1];
    assign ifc.rsp0_ready = rsp_ready[m][0];
    assign ifc.rsp1_ready = rsp_ready[m][1];
    assign req_ready[m][0] = ifc.req0_ready;
    assign req_ready[m][1] = ifc.req1_ready;
    assign rsp_valid[m][0] = ifc.rsp0_valid;
    assign rsp_valid[m][1] = ifc.rsp1_valid;
    assign rsp_result[m]   = ifc.rsp_result;
    assign rsp_z[m]        = ifc.rsp_z;
    assign rsp_err[m]      = ifc.rsp_err;
    assign cnt[m]          = 16'(oc);
    assign alu_out[m]      = (aluop[m] == 3'b111) ? garbage : alu_f(aluop[m], alua[m], alub[m]);
    assign alu_zf[m]       = (aluop[m] == 3'b111) ? 1'b1 : (alu_out[m] == '0);

    alu_share_ctrl #(.WIDTH(W), .ARB_MODE(m), .CNT_W(CW)) u_dut (
      .clk        (clk),
      .clrn       (clrn),
      .bus        (ifc),
      .alua       (alua[m]),
      .alub       (alub[m]),
      .aluop      (aluop[m]),
      .alu_output (alu_out[m]),
      .alu_z      (alu_zf[m]),
      .busy       (busy[m]),
      .op_count   (oc)
    );
  end

  // reference model: 0 = waiting for a request, 1 = executing, 2 = answering
  int           phase [2];
  int           owner [2];
  int           ptr   [2];
  int           count [2];
  int           cmod  [2];
  logic         taken [2][2];
  logic [W-1:0] ea [2];
  logic [W-1:0] eb [2];
  logic [2:0]   eop[2];
  logic [W-1:0] er [2];
  logic         ez [2];
  logic         ee [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      phase[m] = 0; owner[m] = 0; ptr[m] = 0; count[m] = 0;
      ea[m] = '0; eb[m] = '0; eop[m] = '0;
    end
  endtask

  function automatic int winner(input int m);
    if (req_valid[m][0] && req_valid[m][1]) return (m == 1) ? 0 : ptr[m];
    if (req_valid[m][0]) return 0;
    if (req_valid[m][1]) return 1;
    return -1;
  endfunction

  task automatic drive_inputs();
    garbage = $urandom;
    for (int m = 0; m < 2; m++) begin
      for (int p = 0; p < 2; p++) begin
        if (taken[m][p]) begin
          req_valid[m][p] = 1'b0;
          taken[m][p] = 1'b0;
        end
        if (!req_valid[m][p] && $urandom_range(99) < 45) begin
          req_valid[m][p] = 1'b1;
          req_a[m][p]  = ($urandom_range(3) == 0) ? W'($urandom_range(40)) : W'($urandom);
          req_b[m][p]  = ($urandom_range(3) == 0) ? req_a[m][p] : W'($urandom);
          req_op[m][p] = 3'($urandom_range(7));
        end
        rsp_ready[m][p] = ($urandom_range(99) < 60);
      end
    end
  endtask

  task automatic check_and_step(input int m);
    string s;
    int w;
    w = winner(m);
    s = $sformatf("dut%0d", m);
    check({s, " req0_ready"}, W'(req_ready[m][0]), W'(phase[m] == 0 && w == 0));
    check({s, " req1_ready"}, W'(req_ready[m][1]), W'(phase[m] == 0 && w == 1));
    check({s, " rsp0_valid"}, W'(rsp_valid[m][0]), W'(phase[m] == 2 && owner[m] == 0));
    check({s, " rsp1_valid"}, W'(rsp_valid[m][1]), W'(phase[m] == 2 && owner[m] == 1));
    check({s, " busy"},       W'(busy[m]),         W'(phase[m] != 0));
    check({s, " op_count"},   W'(cnt[m]),          W'(count[m]));
    check({s, " alua"},       alua[m],             ea[m]);
    check({s, " alub"},       alub[m],             eb[m]);
    check({s, " aluop"},      W'(aluop[m]),        W'(eop[m]));
    if (phase[m] == 2) begin
      check({s, " rsp_result"}, rsp_result[m], er[m]);
      check({s, " rsp_z"},      W'(rsp_z[m]),   W'(ez[m]));
      check({s, " rsp_err"},    W'(rsp_err[m]), W'(ee[m]));
    end
    // advance the model to what the coming rising edge does
    case (phase[m])
      0: if (w >= 0) begin
        phase[m] = 1;
        owner[m] = w;
        ea[m]  = req_a[m][w];
        eb[m]  = req_b[m][w];
        eop[m] = req_op[m][w];
        taken[m][w] = 1'b1;
        if (eop[m] == 3'b111) begin
          er[m] = '0; ez[m] = 1'b0; ee[m] = 1'b1;
        end else begin
          er[m] = alu_f(eop[m], ea[m], eb[m]);
          ez[m] = (er[m] == '0);
          ee[m] = 1'b0;
        end
      end
      1: phase[m] = 2;
      default: if (rsp_ready[m][owner[m]]) begin
        count[m] = (count[m] + 1) % cmod[m];
        if (m == 0) ptr[m] = 1 - owner[m];
        phase[m] = 0;
      end
    endcase
  endtask

  task automatic cycle_body();
    drive_inputs();
    #1;
    for (int m = 0; m < 2; m++) check_and_step(m);
  endtask

  task automatic reset_checks();
    for (int m = 0; m < 2; m++) begin
      check("rst busy",       W'(busy[m]),         '0);
      check("rst op_count",   W'(cnt[m]),          '0);
      check("rst rsp0_valid", W'(rsp_valid[m][0]), '0);
      check("rst rsp1_valid", W'(rsp_valid[m][1]), '0);
      check("rst alua",       alua[m],             '0);
      check("rst alub",       alub[m],             '0);
      check("rst aluop",      W'(aluop[m]),        '0);
      check("rst rsp_result", rsp_result[m],       '0);
      check("rst rsp_z",      W'(rsp_z[m]),        '0);
      check("rst rsp_err",    W'(rsp_err[m]),      '0);
    end
  endtask

  initial begin
    bit found;
    clrn = 1'b0;
    garbage = '0;
    cmod[0] = 16;
    cmod[1] = 65536;
    for (int m = 0; m < 2; m++) begin
      for (int p = 0; p < 2; p++) begin
        req_valid[m][p] = 1'b0; req_a[m][p] = '0; req_b[m][p] = '0;
        req_op[m][p] = '0; rsp_ready[m][p] = 1'b0; taken[m][p] = 1'b0;
      end
    end
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks();
    clrn = 1'b1;
    cycle_body();
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      cycle_body();
    end
    // abort an op in flight on dut 0 with an asynchronous reset
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      cycle_body();
      if (phase[0] == 1) found = 1'b1;
    end
    check("exec_reached", W'(found), W'(1));
    if (found) begin
      @(posedge clk);
      #1;
      clrn = 1'b0;
      #1;
      reset_checks();
      model_reset();
      @(negedge clk);
      clrn = 1'b1;
      cycle_body();
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      cycle_body();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
